alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 4-bit add/subtract ALU between two requesters. It captures a winner's operands and opcode, drives the ALU's input load registers for one cycle, then samples the ALU result and carry. The result is returned to the winner with a one-cycle done pulse. It sits between the requesting control units and the existing load-register + ALU datapath, and is the only driver of that datapath's load inputs.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_arbiter_if.sv | 36 +++
 rtl/rr_arb_2.sv | 14 +
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

    localparam int WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester handshakes and the ALU load/result datapath signals.
interface alu_arbiter_if import alu_pkg::*; #(
    parameter int W = WIDTH
) ();

    // requester side
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         s0, s1;
    logic         gnt0, gnt1;
    logic         done0, done1;
    logic [W-1:0] result;
    logic         cout;

    // ALU datapath side
    logic [W-1:0] alu_a, alu_b;
    logic         alu_s;
    logic         alu_ld;
    logic [W-1:0] alu_out;
    logic         alu_cout;

    // arbiter view
    modport slave (
        input  req0, req1, a0, b0, a1, b1, s0, s1, alu_out, alu_cout,
        output gnt0, gnt1, done0, done1, result, cout,
               alu_a, alu_b, alu_s, alu_ld
    );

    // environment view: requesters plus the ALU datapath
    modport master (
        output req0, req1, a0, b0, a1, b1, s0, s1, alu_out, alu_cout,
        input  gnt0, gnt1, done0, done1, result, cout,
               alu_a, alu_b, alu_s, alu_ld
    );

endinterface

// File: rtl/rr_arb_2.sv
// Combinational two-way round-robin pick. 'last' is the id served most
// recently; on a tie the other requester wins.
module rr_arb_2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic id,
    output logic vld
);

    assign vld = req0 | req1;
    assign id  = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one add/subtract ALU between two requesters. A winner's operands are
// captured in IDLE, presented with a one-cycle load in LOAD, the ALU result is
// sampled at the end of EXEC, and done is pulsed to the winner in RESP.
module alu_arbiter import alu_pkg::*; #(
    parameter int W = WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t       state, state_nxt;
    logic         ptr;            // id of the requester served last
    logic         win;            // id of the operation in flight
    logic         pick_id, pick_vld;
    logic         take;

    // The ALU operand outputs double as the op registers: they are written
    // only at capture, so they show the operands in LOAD and hold through EXEC.
    logic [W-1:0] op_a, op_b;
    logic         op_s;
    logic [1:0]   gnt_q, done_q;
    logic         ld_q;
    logic [W-1:0] res_q;
    logic         cout_q;

    rr_arb_2 u_arb (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (ptr),
        .id   (pick_id),
        .vld  (pick_vld)
    );

    assign take = (state == IDLE) && pick_vld;

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Fixed IDLE->LOAD->EXEC->RESP->IDLE walk; only IDLE waits on a request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = LOAD;
            LOAD: state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture winner, operands and round-robin pointer on IDLE->LOAD.
    // Pointer resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr  <= 1'b1;
            win  <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            op_s <= 1'b0;
        end else if (take) begin
            ptr  <= pick_id;
            win  <= pick_id;
            op_a <= pick_id ? bus.a1 : bus.a0;
            op_b <= pick_id ? bus.b1 : bus.b0;
            op_s <= pick_id ? bus.s1 : bus.s0;
        end
    end

    // Registered one-cycle pulses: gnt/alu_ld during LOAD, done during RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q  <= '0;
            done_q <= '0;
            ld_q   <= 1'b0;
        end else begin
            gnt_q  <= take ? (2'b01 << pick_id) : 2'b00;
            ld_q   <= take;
            done_q <= (state == EXEC) ? (2'b01 << win) : 2'b00;
        end
    end

    // Result/carry are taken verbatim from the ALU on the EXEC->RESP edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q  <= bus.alu_out;
            cout_q <= bus.alu_cout;
        end
    end

    assign bus.gnt0   = gnt_q[0];
    assign bus.gnt1   = gnt_q[1];
    assign bus.done0  = done_q[0];
    assign bus.done1  = done_q[1];
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.alu_a  = op_a;
    assign bus.alu_b  = op_b;
    assign bus.alu_s  = op_s;
    assign bus.alu_ld = ld_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural load-register + ALU model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // External ALU: load registers plus combinational add/sub.
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    logic [WIDTH:0]   alu_sum;

    always_ff @(posedge clk) begin
        if (bus.alu_ld) begin
            ra <= bus.alu_a;
            rb <= bus.alu_b;
            rs <= bus.alu_s;
        end
    end

    assign alu_sum      = {1'b0, ra} + {1'b0, (rs == OP_SUB) ? ~rb : rb} + {{WIDTH{1'b0}}, rs};
    assign bus.alu_out  = alu_sum[WIDTH-1:0];
    assign bus.alu_cout = alu_sum[WIDTH];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation starting from IDLE; checks every cycle of it.
    task automatic run_op(input string tag, input logic id,
                          input logic [3:0] a, input logic [3:0] b, input logic s,
                          input logic [3:0] er, input logic ec);
        if (id) begin
            bus.a1 = a; bus.b1 = b; bus.s1 = s; bus.req1 = 1'b1;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.s0 = s; bus.req0 = 1'b1;
        end
        tick();  // LOAD
        chk({tag, ".gnt"},  {bus.gnt1, bus.gnt0}, id ? 8'd2 : 8'd1);
        chk({tag, ".ld"},   bus.alu_ld, 8'd1);
        chk({tag, ".alu_a"}, bus.alu_a, a);
        chk({tag, ".alu_b"}, bus.alu_b, b);
        chk({tag, ".alu_s"}, bus.alu_s, s);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();  // EXEC
        chk({tag, ".gnt_off"}, {bus.gnt1, bus.gnt0}, 8'd0);
        chk({tag, ".ld_off"},  bus.alu_ld, 8'd0);
        chk({tag, ".done_early"}, {bus.done1, bus.done0}, 8'd0);
        tick();  // RESP
        chk({tag, ".done"},   {bus.done1, bus.done0}, id ? 8'd2 : 8'd1);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".cout"},   bus.cout, ec);
        tick();  // IDLE
        chk({tag, ".done_off"}, {bus.done1, bus.done0}, 8'd0);
        chk({tag, ".hold"},     bus.result, er);
    endtask

    initial begin
        bit found;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.s0 = 1'b0;
        bus.a1 = '0; bus.b1 = '0; bus.s1 = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst.gnt",    {bus.gnt1, bus.gnt0}, 8'd0);
        chk("rst.done",   {bus.done1, bus.done0}, 8'd0);
        chk("rst.ld",     bus.alu_ld, 8'd0);
        chk("rst.result", bus.result, 8'd0);
        chk("rst.cout",   bus.cout, 8'd0);
        chk("rst.alu",    {bus.alu_s, bus.alu_b, bus.alu_a}, 8'd0);
        rst = 1'b1;
        tick();

        // single add and wrapping add
        run_op("add",  1'b0, 4'd2,  4'd10, OP_ADD, 4'd12, 1'b0);
        run_op("wrap", 1'b1, 4'd13, 4'd7,  OP_ADD, 4'd4,  1'b1);

        // tie right after reset: requester 0 first, then 1, 8 cycles in all
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus.a0 = 4'd6; bus.b0 = 4'd3;  bus.s0 = OP_SUB; bus.req0 = 1'b1;
        bus.a1 = 4'd9; bus.b1 = 4'd12; bus.s1 = OP_SUB; bus.req1 = 1'b1;
        tick();  // LOAD (op 0)
        chk("tie.gnt0", {bus.gnt1, bus.gnt0}, 8'd1);
        bus.req0 = 1'b0;
        tick();  // EXEC
        tick();  // RESP
        chk("tie.done0",   {bus.done1, bus.done0}, 8'd1);
        chk("tie.result0", bus.result, 8'd3);
        chk("tie.cout0",   bus.cout, 8'd1);
        tick();  // IDLE
        chk("tie.idle", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 8'd0);
        tick();  // LOAD (op 1)
        chk("tie.gnt1",  {bus.gnt1, bus.gnt0}, 8'd2);
        chk("tie.alu_a", bus.alu_a, 8'd9);
        bus.req1 = 1'b0;
        tick();  // EXEC
        tick();  // RESP
        chk("tie.done1",   {bus.done1, bus.done0}, 8'd2);
        chk("tie.result1", bus.result, 8'd13);
        chk("tie.cout1",   bus.cout, 8'd0);
        tick();  // IDLE

        // fairness: both requesters keep coming back
        bus.a0 = 4'd1; bus.b0 = 4'd1; bus.s0 = OP_ADD;
        bus.a1 = 4'd3; bus.b1 = 4'd1; bus.s1 = OP_SUB;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            for (int t = 0; t < 8 && !found; t++) begin
                tick();
                if (bus.gnt0 | bus.gnt1) found = 1'b1;
            end
            chk("fair.found", 8'(found), 8'd1);
            chk("fair.order", {bus.gnt1, bus.gnt0}, (k % 2) ? 8'd2 : 8'd1);
            if (bus.gnt1) bus.req1 = 1'b0;
            else          bus.req0 = 1'b0;
            tick();
            if (k < 5) begin
                bus.req0 = 1'b1;
                bus.req1 = 1'b1;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();  // RESP of last op (requester 1: 3-1)
        chk("fair.last_done", {bus.done1, bus.done0}, 8'd2);
        chk("fair.last_res",  bus.result, 8'd2);
        tick();  // IDLE

        // operand change in the gnt cycle must not leak into the operation
        bus.a0 = 4'd2; bus.b0 = 4'd10; bus.s0 = OP_ADD; bus.req0 = 1'b1;
        tick();  // LOAD
        chk("stab.gnt", {bus.gnt1, bus.gnt0}, 8'd1);
        bus.a0 = 4'd15;
        bus.req0 = 1'b0;
        tick();  // EXEC
        chk("stab.alu_a", bus.alu_a, 8'd2);
        tick();  // RESP
        chk("stab.done",   {bus.done1, bus.done0}, 8'd1);
        chk("stab.result", bus.result, 8'd12);
        tick();  // IDLE

        // reset during EXEC aborts without done
        bus.a0 = 4'd5; bus.b0 = 4'd4; bus.s0 = OP_ADD; bus.req0 = 1'b1;
        tick();  // LOAD
        bus.req0 = 1'b0;
        tick();  // EXEC
        rst = 1'b0;
        #1;
        chk("abort.gnt",    {bus.gnt1, bus.gnt0}, 8'd0);
        chk("abort.done",   {bus.done1, bus.done0}, 8'd0);
        chk("abort.ld",     bus.alu_ld, 8'd0);
        chk("abort.result", bus.result, 8'd0);
        tick();
        tick();
        chk("abort.no_done", {bus.done1, bus.done0}, 8'd0);
        chk("abort.res_held", bus.result, 8'd0);
        rst = 1'b1;
        tick();
        run_op("post_rst", 1'b0, 4'd5, 4'd4, OP_ADD, 4'd9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
